hk_onchip_ram_pipe: RTL and testbench

- Parametrised Avalon-MM single-port on-chip RAM slave for the Hollow Knight SoC.
- Successor to the fixed 4-word, 32-bit, unregistered-output on-chip memory.
- Adds configurable width, depth and read latency, plus readdatavalid and waitrequest handshakes.
- Adds a hardware clear-on-reset sequencer, so the CPU and sprite/level tables see a known memory state without a hex init file.

---
 rtl/hk_mem_pkg.sv | 20 ++
 rtl/hk_ram_core.sv | 39 +++
 rtl/hk_onchip_ram_pipe.sv | 195 +++++++++++++++++++
 tb/tb_hk_onchip_ram_pipe.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hk_mem_pkg.sv
// Shared types and helpers for the Hollow Knight on-chip RAM.
// FSM state encoding, legal read-latency range and the byte-lane parity function.
package hk_mem_pkg;

  typedef logic [0:0] state_t;

  localparam state_t ST_CLEAR = 1'b0;
  localparam state_t ST_READY = 1'b1;

  localparam int RL_MIN = 1;
  localparam int RL_MAX = 2;

  localparam int BYTE_W = 8;

  // Even parity: the stored bit makes the total count of ones in the lane even.
  function automatic logic byte_parity(input logic [BYTE_W-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/hk_ram_core.sv
// Inferred single-port RAM with per-lane write enables and a registered read port.
// Contents are never reset; only writes through the port change them.
module hk_ram_core
  import hk_mem_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int LANE_W = BYTE_W,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic                    re,
  input  logic [ADDR_W-1:0]       addr,
  input  logic [LANES-1:0]        be,
  input  logic [LANES*LANE_W-1:0] wdata,
  output logic [LANES*LANE_W-1:0] rdata
);

  logic [LANES*LANE_W-1:0] mem [DEPTH];
  logic [LANES*LANE_W-1:0] rdata_q;

  // Read register lives in the same block as the array so tools map it onto block RAM.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata_q <= mem[addr];
    end
    if (we) begin
      for (int i = 0; i < LANES; i++) begin
        if (be[i]) begin
          mem[addr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
        end
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/hk_onchip_ram_pipe.sv
// Avalon-MM on-chip RAM slave: clear-on-reset FSM, request acceptance and read-latency pipeline.
// Define HK_RAM_PARITY_EN to store per-byte even parity and expose the parity_err output.
module hk_onchip_ram_pipe
  import hk_mem_pkg::*;
#(
  parameter int                DATA_W         = 32,
  parameter int                DEPTH          = 1024,
  parameter int                ADDR_W         = $clog2(DEPTH),
  parameter int                READ_LATENCY   = 1,
  parameter int                CLEAR_ON_RESET = 1,
  parameter logic [DATA_W-1:0] FILL_VALUE     = '0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W/8-1:0] byteenable,
  input  logic                chipselect,
  input  logic                read,
  input  logic                write,
  input  logic [DATA_W-1:0]   writedata,
  input  logic                clken,
  output logic [DATA_W-1:0]   readdata,
  output logic                readdatavalid,
  output logic                waitrequest,
  output logic                init_done
`ifdef HK_RAM_PARITY_EN
  ,
  output logic                parity_err
`endif
);

  localparam int NB = DATA_W / BYTE_W;
`ifdef HK_RAM_PARITY_EN
  localparam int LANE_W = BYTE_W + 1;
`else
  localparam int LANE_W = BYTE_W;
`endif
  localparam int                RL        = (READ_LATENCY >= RL_MAX) ? RL_MAX : RL_MIN;
  localparam int                SW        = NB * LANE_W;
  localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam state_t            ST_RESET  = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              init_done_q, init_done_d;
  logic [RL-1:0]     vld_q, vld_d;
  logic              oor_q, oor_d;

  logic              clearing, addr_ok, accept, wr_acc, rd_acc;
  logic              core_we, core_re;
  logic [ADDR_W-1:0] core_addr;
  logic [NB-1:0]     core_be;
  logic [DATA_W-1:0] wr_word, rd_word, s1_data;
  logic [SW-1:0]     core_wdata, core_rdata;

  assign clearing    = (state_q == ST_CLEAR);
  assign waitrequest = ~init_done_q | ~clken;
  assign init_done   = init_done_q;
  assign addr_ok     = ({1'b0, address} < DEPTH_X);
  assign accept      = chipselect & (read | write) & ~waitrequest;
  assign wr_acc      = accept & write;
  assign rd_acc      = accept & read & ~write;

  // init_done rises on the same edge that retires the last clear write.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    if (clken) begin
      if (clearing) begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == LAST_ADDR) begin
          state_d     = ST_READY;
          cnt_d       = '0;
          init_done_d = 1'b1;
        end
      end else begin
        init_done_d = 1'b1;
      end
    end
  end

  always_comb begin
    vld_d = vld_q;
    oor_d = oor_q;
    if (clken) begin
      vld_d[0] = rd_acc;
      oor_d    = ~addr_ok;
      for (int i = 1; i < RL; i++) begin
        vld_d[i] = vld_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_RESET;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      vld_q       <= '0;
      oor_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      vld_q       <= vld_d;
      oor_q       <= oor_d;
    end
  end

  assign core_we   = clken & (clearing | (wr_acc & addr_ok));
  assign core_re   = rd_acc & addr_ok;
  assign core_addr = clearing ? cnt_q : address;
  assign core_be   = clearing ? '1 : byteenable;
  assign wr_word   = clearing ? FILL_VALUE : writedata;

`ifdef HK_RAM_PARITY_EN
  logic [NB-1:0] lane_err;
  logic          s1_err, out_err;
`endif

  for (genvar i = 0; i < NB; i++) begin : g_lane
    assign core_wdata[i*LANE_W +: BYTE_W] = wr_word[i*BYTE_W +: BYTE_W];
    assign rd_word[i*BYTE_W +: BYTE_W]    = core_rdata[i*LANE_W +: BYTE_W];
`ifdef HK_RAM_PARITY_EN
    assign core_wdata[i*LANE_W + BYTE_W] = byte_parity(wr_word[i*BYTE_W +: BYTE_W]);
    assign lane_err[i] = core_rdata[i*LANE_W + BYTE_W] ^ byte_parity(rd_word[i*BYTE_W +: BYTE_W]);
`endif
  end

  hk_ram_core #(
    .LANES  (NB),
    .LANE_W (LANE_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_core (
    .clk   (clk),
    .we    (core_we),
    .re    (core_re),
    .addr  (core_addr),
    .be    (core_be),
    .wdata (core_wdata),
    .rdata (core_rdata)
  );

  // Out-of-range reads never touch the array, so their data is forced to zero here.
  assign s1_data = (vld_q[0] & ~oor_q) ? rd_word : '0;
`ifdef HK_RAM_PARITY_EN
  assign s1_err  = vld_q[0] & ~oor_q & (|lane_err);
`endif

  if (RL == 2) begin : g_rl2
    logic [DATA_W-1:0] data2_q, data2_d;

    always_comb begin
      data2_d = data2_q;
      if (clken) data2_d = s1_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) data2_q <= '0;
      else          data2_q <= data2_d;
    end

    assign readdata = data2_q;

`ifdef HK_RAM_PARITY_EN
    logic err2_q, err2_d;

    always_comb begin
      err2_d = err2_q;
      if (clken) err2_d = s1_err;
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) err2_q <= 1'b0;
      else          err2_q <= err2_d;
    end

    assign out_err = err2_q;
`endif
  end else begin : g_rl1
    assign readdata = s1_data;
`ifdef HK_RAM_PARITY_EN
    assign out_err  = s1_err;
`endif
  end

  assign readdatavalid = vld_q[RL-1] & clken;
`ifdef HK_RAM_PARITY_EN
  assign parity_err    = out_err & readdatavalid;
`endif

endmodule

// File: tb/tb_hk_onchip_ram_pipe.sv
// Scoreboard bench for hk_onchip_ram_pipe: two instances (DEPTH 8 / latency 1, DEPTH 6 / latency 2)
// share one bus; a behavioural memory model predicts every read and a monitor checks timing and data.
module tb_hk_onchip_ram_pipe;

  localparam logic [31:0] FILL    = 32'hDEAD_BEEF;
  localparam int          DEPTH_A = 8;
  localparam int          DEPTH_B = 6;
  localparam int          RL_A    = 1;
  localparam int          RL_B    = 2;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n, chipselect, read, write, clken;
  logic [2:0]  address;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic [31:0] rd_a, rd_b;
  logic        rv_a, rv_b, wait_a, wait_b, done_a, done_b;
`ifdef HK_RAM_PARITY_EN
  logic        perr_a, perr_b;
`endif

  int          compared   = 0;
  int          mismatched = 0;
  int          en_edges   = 0;
  bit          ready      = 1'b0;
  logic [31:0] mem_a [DEPTH_A];
  logic [31:0] mem_b [DEPTH_B];
  exp_t        exp_a [$];
  exp_t        exp_b [$];

  always #5 clk = ~clk;

  always @(posedge clk) if (clken) en_edges <= en_edges + 1;

  hk_onchip_ram_pipe #(
    .DATA_W (32), .DEPTH (DEPTH_A), .READ_LATENCY (RL_A),
    .CLEAR_ON_RESET (1), .FILL_VALUE (FILL)
  ) dut_a (
    .clk (clk), .reset_n (reset_n), .address (address), .byteenable (byteenable),
    .chipselect (chipselect), .read (read), .write (write), .writedata (writedata),
    .clken (clken), .readdata (rd_a), .readdatavalid (rv_a), .waitrequest (wait_a),
    .init_done (done_a)
`ifdef HK_RAM_PARITY_EN
    , .parity_err (perr_a)
`endif
  );

  hk_onchip_ram_pipe #(
    .DATA_W (32), .DEPTH (DEPTH_B), .READ_LATENCY (RL_B),
    .CLEAR_ON_RESET (1), .FILL_VALUE (FILL)
  ) dut_b (
    .clk (clk), .reset_n (reset_n), .address (address), .byteenable (byteenable),
    .chipselect (chipselect), .read (read), .write (write), .writedata (writedata),
    .clken (clken), .readdata (rd_b), .readdatavalid (rv_b), .waitrequest (wait_b),
    .init_done (done_b)
`ifdef HK_RAM_PARITY_EN
    , .parity_err (perr_b)
`endif
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = nw[i*8 +: 8];
    return r;
  endfunction

  // Drives one bus cycle starting just after a rising edge; the model predicts its effect.
  task automatic applyStimulus(input bit cs, input bit rd, input bit wr, input bit ce,
                               input logic [2:0] a, input logic [3:0] be, input logic [31:0] d);
    bit acc;
    chipselect = cs; read = rd; write = wr; clken = ce;
    address = a; byteenable = be; writedata = d;
    acc = ready && cs && ce && (rd || wr);
    if (acc && wr) begin
      mem_a[a] = merge(mem_a[a], d, be);
      if (int'(a) < DEPTH_B) mem_b[a] = merge(mem_b[a], d, be);
    end else if (acc) begin
      exp_a.push_back('{data: mem_a[a], due: en_edges + RL_A});
      exp_b.push_back('{data: (int'(a) < DEPTH_B) ? mem_b[a] : 32'h0, due: en_edges + RL_B});
    end
    #1;
    if (ready) begin
      checkOutput("A_waitrequest", 32'(wait_a), 32'(!ce));
      checkOutput("B_waitrequest", 32'(wait_b), 32'(!ce));
    end
    @(posedge clk); #1;
    chipselect = 1'b0; read = 1'b0; write = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 1, 3'd0, 4'h0, 32'h0);
  endtask

  // Releases reset and counts stalled cycles while each instance clears itself.
  task automatic releaseAndCountClear();
    int cnt_a = 0;
    int cnt_b = 0;
    reset_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      cnt_a += int'(wait_a);
      cnt_b += int'(wait_b);
    end
    checkOutput("A_clear_cycles", 32'(cnt_a), 32'(DEPTH_A));
    checkOutput("B_clear_cycles", 32'(cnt_b), 32'(DEPTH_B));
    checkOutput("A_init_done", 32'(done_a), 32'd1);
    checkOutput("B_init_done", 32'(done_b), 32'd1);
    for (int i = 0; i < DEPTH_A; i++) mem_a[i] = FILL;
    for (int i = 0; i < DEPTH_B; i++) mem_b[i] = FILL;
    ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic enterReset();
    reset_n = 1'b0;
    ready   = 1'b0;
    exp_a.delete();
    exp_b.delete();
  endtask

  // Monitor: a valid is due on the enabled cycle the model scheduled, never earlier or later.
  always @(negedge clk) begin
    exp_t e;
    bit   ev;
    if (exp_a.size() > 0 && exp_a[0].due < en_edges) begin
      void'(exp_a.pop_front());
      compared++; mismatched++;
      $display("[TB] FAIL A_missed_valid: got no readdatavalid, required one (t=%0t)", $time);
    end
    ev = clken && exp_a.size() > 0 && exp_a[0].due == en_edges;
    if (ev || rv_a) begin
      checkOutput("A_readdatavalid", 32'(rv_a), 32'(ev));
      if (ev) begin
        e = exp_a.pop_front();
        if (rv_a) checkOutput("A_readdata", rd_a, e.data);
      end
`ifdef HK_RAM_PARITY_EN
      checkOutput("A_parity_err", 32'(perr_a), 32'd0);
`endif
    end
    if (exp_b.size() > 0 && exp_b[0].due < en_edges) begin
      void'(exp_b.pop_front());
      compared++; mismatched++;
      $display("[TB] FAIL B_missed_valid: got no readdatavalid, required one (t=%0t)", $time);
    end
    ev = clken && exp_b.size() > 0 && exp_b[0].due == en_edges;
    if (ev || rv_b) begin
      checkOutput("B_readdatavalid", 32'(rv_b), 32'(ev));
      if (ev) begin
        e = exp_b.pop_front();
        if (rv_b) checkOutput("B_readdata", rd_b, e.data);
      end
`ifdef HK_RAM_PARITY_EN
      checkOutput("B_parity_err", 32'(perr_b), 32'd0);
`endif
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n = 1'b0; clken = 1'b1; chipselect = 1'b0; read = 1'b0; write = 1'b0;
    address = '0; byteenable = '0; writedata = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("A_reset_readdata", rd_a, 32'h0);
    checkOutput("B_reset_readdata", rd_b, 32'h0);
    checkOutput("A_reset_valid", 32'(rv_a), 32'd0);
    checkOutput("B_reset_valid", 32'(rv_b), 32'd0);
    checkOutput("A_reset_waitrequest", 32'(wait_a), 32'd1);
    checkOutput("B_reset_waitrequest", 32'(wait_b), 32'd1);
    checkOutput("A_reset_init_done", 32'(done_a), 32'd0);
    checkOutput("B_reset_init_done", 32'(done_b), 32'd0);
`ifdef HK_RAM_PARITY_EN
    checkOutput("A_reset_parity_err", 32'(perr_a), 32'd0);
    checkOutput("B_reset_parity_err", 32'(perr_b), 32'd0);
`endif
    @(posedge clk); #1;
    releaseAndCountClear();

    for (int a = 0; a < 8; a++) applyStimulus(1, 1, 0, 1, 3'(a), 4'hF, 32'h0);
    idle(3);

    $display("[TB] byte-merge and write-then-read");
    applyStimulus(1, 0, 1, 1, 3'd3, 4'hF, 32'h1122_3344);
    applyStimulus(1, 0, 1, 1, 3'd3, 4'b0101, 32'hAABB_CCDD);
    applyStimulus(1, 1, 0, 1, 3'd3, 4'hF, 32'h0);
    idle(3);

    $display("[TB] back-to-back reads");
    applyStimulus(1, 0, 1, 1, 3'd0, 4'hF, 32'h0101_0101);
    applyStimulus(1, 0, 1, 1, 3'd1, 4'hF, 32'h0202_0202);
    applyStimulus(1, 0, 1, 1, 3'd2, 4'hF, 32'h0303_0303);
    for (int a = 0; a < 3; a++) applyStimulus(1, 1, 0, 1, 3'(a), 4'hF, 32'h0);
    idle(3);

    $display("[TB] read+write together, empty byteenable, out-of-range");
    applyStimulus(1, 1, 1, 1, 3'd4, 4'hF, 32'h55AA_66BB);
    applyStimulus(1, 0, 1, 1, 3'd4, 4'h0, 32'hFFFF_0000);
    applyStimulus(1, 1, 0, 1, 3'd4, 4'hF, 32'h0);
    applyStimulus(1, 0, 1, 1, 3'd7, 4'hF, 32'hFFFF_FFFF);
    applyStimulus(1, 1, 0, 1, 3'd7, 4'hF, 32'h0);
    applyStimulus(1, 1, 0, 1, 3'd5, 4'hF, 32'h0);
    idle(3);

    $display("[TB] clken stall after accepted read");
    applyStimulus(1, 1, 0, 1, 3'd1, 4'hF, 32'h0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, 0, 3'd2, 4'hF, 32'h0);
    idle(4);

    $display("[TB] reset during an in-flight read and during clear");
    applyStimulus(1, 1, 0, 1, 3'd2, 4'hF, 32'h0);
    enterReset();
    @(negedge clk);
    checkOutput("A_flush_valid", 32'(rv_a), 32'd0);
    checkOutput("B_flush_valid", 32'(rv_b), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    enterReset();
    @(posedge clk); #1;
    releaseAndCountClear();
    for (int a = 0; a < 8; a++) applyStimulus(1, 1, 0, 1, 3'(a), 4'hF, 32'h0);
    idle(3);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 300; n++) begin
      int op;
      op = $urandom_range(0, 9);
      applyStimulus($urandom_range(0, 7) != 0, (op < 5) || (op == 9), op >= 5,
                    $urandom_range(0, 7) != 0, 3'($urandom_range(0, 7)), 4'($urandom),
                    $urandom);
    end
    idle(6);
    checkOutput("A_queue_drained", 32'(exp_a.size()), 32'd0);
    checkOutput("B_queue_drained", 32'(exp_b.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
